// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential signed divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_OUTPUT = 2'd2
    } state_t;

    localparam int DIV_N_W = 8;
    localparam int DIV_D_W = 4;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference only when it does not borrow.
module div_step
    import div_pkg::*;
#(
    parameter int D_W = DIV_D_W
) (
    input  logic [D_W:0] rem_i,
    input  logic         bit_i,
    input  logic [D_W:0] dmag_i,
    output logic [D_W:0] rem_o,
    output logic         qbit_o
);

    logic [D_W+1:0] shift_s;
    logic [D_W+1:0] dext_s;

    // Trial subtraction and quotient bit select
    always_comb begin
        shift_s = {rem_i, bit_i};
        dext_s  = {1'b0, dmag_i};
        if (shift_s >= dext_s) begin
            qbit_o = 1'b1;
            rem_o  = (D_W+1)'(shift_s - dext_s);
        end else begin
            qbit_o = 1'b0;
            rem_o  = shift_s[D_W:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: magnitudes are divided one quotient bit per cycle,
// signs are applied on the way out, with divide-by-zero and overflow handling.
module div_seq
    import div_pkg::*;
#(
    parameter int N_W = DIV_N_W,
    parameter int D_W = DIV_D_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] a,
    input  logic [D_W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [N_W-1:0] q,
    output logic [D_W-1:0] r,
    output logic           dbz,
    output logic           ovf
);

    localparam int             CNT_W   = (N_W > 1) ? $clog2(N_W) : 1;
    localparam logic [N_W:0]   MIN_MAG = {2'b01, {(N_W-1){1'b0}}};
    localparam logic [N_W-1:0] Q_SAT   = {1'b0, {(N_W-1){1'b1}}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_W-1:0]   dvd_q, dvd_d;
    logic [D_W:0]     rem_q, rem_d;
    logic [D_W:0]     dmag_q, dmag_d;
    logic             sa_q, sa_d, sb_q, sb_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             dbz_q, dbz_d, ovf_q, ovf_d;
    logic [N_W-1:0]   q_q, q_d;
    logic [D_W-1:0]   r_q, r_d;

    logic [N_W:0]     a_mag_s;
    logic [D_W:0]     b_mag_s;
    logic [D_W:0]     rem_step_s;
    logic             qbit_s;
    logic [N_W-1:0]   quo_s;

    // One extra bit so the most negative dividend has an exact magnitude
    assign a_mag_s = a[N_W-1] ? -{a[N_W-1], a} : {a[N_W-1], a};
    assign b_mag_s = b[D_W-1] ? -{b[D_W-1], b} : {b[D_W-1], b};
    assign quo_s   = {dvd_q[N_W-2:0], qbit_s};

    div_step #(.D_W(D_W)) u_step (
        .rem_i  (rem_q),
        .bit_i  (dvd_q[N_W-1]),
        .dmag_i (dmag_q),
        .rem_o  (rem_step_s),
        .qbit_o (qbit_s)
    );

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        dmag_d     = dmag_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        q_d        = q_q;
        r_d        = r_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d       = a[N_W-1];
                    sb_d       = b[D_W-1];
                    dvd_d      = N_W'(a_mag_s);
                    dmag_d     = b_mag_s;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(N_W - 1);
                    ovf_pend_d = (a_mag_s == MIN_MAG) && (b == '1);
                    busy_d     = 1'b1;
                    if (b == '0) begin
                        state_d = ST_OUTPUT;
                        done_d  = 1'b1;
                        q_d     = '1;
                        r_d     = a[D_W-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_DIVIDE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                dvd_d = quo_s;
                rem_d = rem_step_s;
                if (cnt_q == '0) begin
                    state_d = ST_OUTPUT;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                    if (ovf_pend_q) begin
                        q_d   = Q_SAT;
                        r_d   = '0;
                        ovf_d = 1'b1;
                    end else begin
                        q_d   = (sa_q ^ sb_q) ? -quo_s : quo_s;
                        r_d   = D_W'(sa_q ? -rem_step_s : rem_step_s);
                        ovf_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dmag_q     <= '0;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dmag_q     <= dmag_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
            q_q        <= q_d;
            r_q        <= r_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign q    = q_q;
    assign r    = r_q;
    assign dbz  = dbz_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized
// operands against an integer-arithmetic reference model.
module tb_div_seq;

    localparam int N_W = 8;
    localparam int D_W = 4;
    localparam int LAT = N_W + 1;

    logic           clk;
    logic           rst;
    logic           start;
    logic [N_W-1:0] a;
    logic [D_W-1:0] b;
    logic           busy;
    logic           done;
    logic [N_W-1:0] q;
    logic [D_W-1:0] r;
    logic           dbz;
    logic           ovf;

    int checks = 0;
    int errors = 0;

    div_seq #(.N_W(N_W), .D_W(D_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed integer division, truncating toward zero
    function automatic void model(input logic [N_W-1:0] av, input logic [D_W-1:0] bv,
                                  output logic [N_W-1:0] eq, output logic [D_W-1:0] er,
                                  output logic edbz, output logic eovf);
        int ai;
        int bi;
        ai = $signed(av);
        bi = $signed(bv);
        edbz = 1'b0;
        eovf = 1'b0;
        if (bi == 0) begin
            edbz = 1'b1;
            eq   = '1;
            er   = av[D_W-1:0];
        end else if (ai == -(1 << (N_W - 1)) && bi == -1) begin
            eovf = 1'b1;
            eq   = N_W'((1 << (N_W - 1)) - 1);
            er   = '0;
        end else begin
            eq = N_W'(ai / bi);
            er = D_W'(ai % bi);
        end
    endfunction

    // Launch one operation and return the cycle (1 = first after sampling edge) in which done rose; 0 if never
    task automatic run_op(input logic [N_W-1:0] av, input logic [D_W-1:0] bv, output int lat);
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = N_W'($urandom);
        b = D_W'($urandom);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'd5; b = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, q, r, dbz, ovf} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0", busy, done, q, r, dbz, ovf);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [N_W-1:0] va [6] = '{8'd100, 8'h9C, 8'd100, 8'd7, 8'h80, 8'h80};
        logic [D_W-1:0] vb [6] = '{4'd7,   4'd7,  4'h9,   4'd0, 4'hF,  4'h1};
        logic [N_W-1:0] eq [6] = '{8'h0E,  8'hF2, 8'hF2,  8'hFF, 8'h7F, 8'h80};
        logic [D_W-1:0] er [6] = '{4'h2,   4'hE,  4'h2,   4'h7, 4'h0,  4'h0};
        logic           ez [6] = '{1'b0,   1'b0,  1'b0,   1'b1, 1'b0,  1'b0};
        logic           eo [6] = '{1'b0,   1'b0,  1'b0,   1'b0, 1'b1,  1'b0};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], lat);
            checks++;
            if (lat !== ((vb[i] == 4'd0) ? 1 : LAT)) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want %0d", i, lat, (vb[i] == 4'd0) ? 1 : LAT);
            end
            checks++;
            if ({q, r, dbz, ovf, busy} !== {eq[i], er[i], ez[i], eo[i], 1'b1}) begin
                errors++;
                $display("FAIL dir%0d_result got q=%h r=%h dbz=%b ovf=%b busy=%b want q=%h r=%h dbz=%b ovf=%b busy=1",
                         i, q, r, dbz, ovf, busy, eq[i], er[i], ez[i], eo[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [N_W-1:0] av, eq;
        logic [D_W-1:0] bv, er;
        logic           ez, eo;
        int lat;
        for (int i = 0; i < 40; i++) begin
            av = N_W'($urandom);
            bv = D_W'($urandom);
            if ($urandom_range(0, 5) == 0) av = 8'h80;
            if ($urandom_range(0, 7) == 0) bv = 4'hF;
            if ($urandom_range(0, 9) == 0) bv = 4'h0;
            model(av, bv, eq, er, ez, eo);
            run_op(av, bv, lat);
            checks++;
            if (lat !== (ez ? 1 : LAT) || {q, r, dbz, ovf} !== {eq, er, ez, eo}) begin
                errors++;
                $display("FAIL rand_a%0d_b%0d got lat=%0d q=%h r=%h dbz=%b ovf=%b want lat=%0d q=%h r=%h dbz=%b ovf=%b",
                         $signed(av), $signed(bv), lat, q, r, dbz, ovf, ez ? 1 : LAT, eq, er, ez, eo);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || {q, r} !== {eq, er}) begin
                errors++;
                $display("FAIL rand_after_done got done=%b busy=%b q=%h r=%h want 0 0 %h %h", done, busy, q, r, eq, er);
            end
        end
    endtask

    task automatic test_hold();
        logic [N_W-1:0] eq;
        logic [D_W-1:0] er;
        logic           ez, eo;
        int lat;
        model(8'hC5, 4'h3, eq, er, ez, eo);
        run_op(8'hC5, 4'h3, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = N_W'($urandom); b = D_W'($urandom);
            checks++;
            if ({done, busy, q, r, dbz, ovf} !== {1'b0, 1'b0, eq, er, ez, eo}) begin
                errors++;
                $display("FAIL hold_idle got done=%b busy=%b q=%h r=%h want 0 0 %h %h", done, busy, q, r, eq, er);
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        @(negedge clk);
        a = 8'd50; b = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 4) begin a = 8'd9; b = 4'd2; start = 1'b1; end
            if (k == 5) start = 1'b0;
            if (done === 1'b1) begin lat = k; break; end
            @(negedge clk);
        end
        checks++;
        if (lat !== LAT || q !== 8'd16 || r !== 4'd2) begin
            errors++;
            $display("FAIL ignore_start got lat=%0d q=%h r=%h want lat=%0d q=10 r=2", lat, q, r, LAT);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen = 0;
        @(negedge clk);
        a = 8'd50; b = 4'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, q, r, dbz, ovf} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0", busy, done, q, r, dbz, ovf);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d active cycles want 0", seen);
        end
        run_op(8'hF7, 4'd4, lat);
        checks++;
        if (lat !== LAT || q !== 8'hFE || r !== 4'hF || dbz !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort_fresh got lat=%0d q=%h r=%h dbz=%b ovf=%b want lat=%0d q=fe r=f 0 0", lat, q, r, dbz, ovf, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int lat1 = 0;
        int lat2 = 0;
        @(negedge clk);
        a = 8'd100; b = 4'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int k = 1; k <= 30; k++) begin
            if (done === 1'b1 && lat1 == 0) begin
                lat1 = k;
                checks++;
                if (q !== 8'h0E || r !== 4'h2) begin
                    errors++;
                    $display("FAIL b2b_first got q=%h r=%h want 0e 2", q, r);
                end
                a = 8'h9C;
            end else if (done === 1'b1) begin
                lat2 = k;
                break;
            end
            if (k == lat1 + 2 && lat1 != 0) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat1 !== LAT || lat2 !== 2 * LAT + 1) begin
            errors++;
            $display("FAIL b2b_latency got %0d,%0d want %0d,%0d", lat1, lat2, LAT, 2 * LAT + 1);
        end
        checks++;
        if (q !== 8'hF2 || r !== 4'hE) begin
            errors++;
            $display("FAIL b2b_second got q=%h r=%h want f2 e", q, r);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter N_W, default 8, dividend/quotient width in bits.
REQ-002 Parameter D_W, default 4, divisor/remainder width in bits; D_W <= N_W.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  N_W  signed dividend (two's complement).
REQ-007 b  input  D_W  signed divisor (two's complement).
REQ-008 busy  output  1  high in DIVIDE and OUTPUT.
REQ-009 done  output  1  one-cycle pulse; q/r/flags valid from that cycle.
REQ-010 q  output  N_W  signed quotient, registered.
REQ-011 r  output  D_W  signed remainder, registered.
REQ-012 dbz  output  1  divide-by-zero flag, valid with done.
REQ-013 ovf  output  1  quotient overflow flag, valid with done.

Function
REQ-014 FSM states: IDLE, DIVIDE, OUTPUT; encoded 2 bits.
REQ-015 IDLE + start=1: capture a and b and their signs; go to DIVIDE; if b==0, go to OUTPUT directly.
REQ-016 IDLE + start=0: remain IDLE; all outputs hold.
REQ-017 DIVIDE: unsigned restoring division on |a| by |b|, one quotient bit per cycle, MSB first, exactly N_W cycles; iteration counter counts N_W-1 down to 0.
REQ-018 Magnitudes computed at N_W+1 bits so |-2^(N_W-1)| is exact.
REQ-019 After last iteration: go to OUTPUT.
REQ-020 OUTPUT: register q, r, dbz, ovf; assert done for this one cycle; next state IDLE.
REQ-021 Latency: done high N_W+1 cycles after the start-sampling edge; 1 cycle for b==0.
REQ-022 Rounding: truncation toward zero; q negative iff signs of a and b differ and magnitude nonzero; r takes sign of a; a == q*b + r holds whenever dbz=0 and ovf=0.
REQ-023 b==0: dbz=1, ovf=0, q = all ones, r = low D_W bits of a.
REQ-024 a = -2^(N_W-1) and b = -1: ovf=1, q = 2^(N_W-1)-1 (saturated), r = 0.
REQ-025 Otherwise dbz=0, ovf=0.
REQ-026 start while busy: ignored; no effect on operation in progress.
REQ-027 a/b changes after capture: no effect until next accepted start.
REQ-028 q, r, dbz, ovf hold last result until the next OUTPUT state; done=0 outside OUTPUT.
REQ-029 start high in the cycle done is high: ignored (FSM in OUTPUT); accepted next cycle if still high.

Reset
REQ-030 rst=1 at a clock edge: state IDLE, busy=0, done=0, q=0, r=0, dbz=0, ovf=0, counter and working registers cleared.
REQ-031 rst asserted mid-DIVIDE or in OUTPUT aborts the operation; no done pulse for it.
REQ-032 rst has priority over start in the same cycle.

Structure
REQ-033 Shared package div_pkg holds state typedef (IDLE/DIVIDE/OUTPUT) and default width constants N_W=8, D_W=4.
REQ-034 One sub-module natural: div_step -- combinational single restoring step (shift, trial subtract, quotient bit select); instantiated once.
REQ-035 No multi-cycle combinational paths; no latches.

Verification
REQ-036 a=100, b=7, start 1 cycle -> after 9 cycles done=1, q=8'h0E (14), r=4'h2, dbz=0, ovf=0.
REQ-037 a=-100, b=7 -> q=8'hF2 (-14), r=4'hE (-2); a=100, b=-7 -> q=8'hF2, r=4'h2.
REQ-038 a=7, b=0 -> done 1 cycle after start, dbz=1, q=8'hFF, r=4'h7.
REQ-039 a=-128, b=-1 -> ovf=1, q=8'h7F, r=0; a=-128, b=1 -> q=8'h80, ovf=0.
REQ-040 Start a=50, b=3; at DIVIDE cycle 4 pulse start with a=9, b=2 -> ignored, result q=16, r=2.
REQ-041 Start a=50, b=3; rst=1 at DIVIDE cycle 3 -> all outputs 0, IDLE next cycle, no done; fresh start a=-9, b=4 -> q=-2 (8'hFE), r=-1 (4'hF).
